// File: rtl/serial_encode.sv
`default_nettype none
// ============================================================================
//  Module      : serial_encode
//  Description : Thermostat serial link transmitter. Captures a 192-bit frame
//                (constant header + payload inputs) on a start/ready handshake
//                and shifts it out MSB-first, one bit per BIT_PERIOD clocks,
//                with a one-cycle sample strobe mid-bit, then idles for
//                GAP_CYCLES clocks before accepting the next frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_encode #(
    parameter logic [31:0] PREAMBLE   = 32'hAAAA_AAAA,
    parameter logic [15:0] TYPE_1     = 16'hD391,
    parameter logic [15:0] TYPE_2     = 16'hD391,
    parameter logic [31:0] CONSTANT   = 32'h0DFF_FFFE,
    parameter int          BIT_PERIOD = 4,
    parameter int          GAP_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        ready,
    input  logic [31:0] thermostat_id,
    input  logic [15:0] room_temp,
    input  logic [15:0] set_temp,
    input  logic [7:0]  state,
    input  logic [7:0]  tail_1,
    input  logic [7:0]  tail_2,
    input  logic [7:0]  tail_3,
    output logic        serial_data,
    output logic        serial_clock,
    output logic        busy,
    output logic        done
);

    localparam int                 c_phase_w      = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [c_phase_w-1:0] c_phase_last   = c_phase_w'(BIT_PERIOD - 1);
    localparam logic [c_phase_w-1:0] c_phase_strobe = c_phase_w'(BIT_PERIOD / 2);
    localparam logic [c_phase_w-1:0] c_phase_one    = c_phase_w'(1);
    localparam logic [15:0]        c_gap_last     = 16'(GAP_CYCLES - 1);
    localparam logic               c_has_gap      = (GAP_CYCLES != 0);
    localparam logic [7:0]         c_last_bit     = 8'd191;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [191:0]           r_frame;
    logic [7:0]             r_idx;
    logic [c_phase_w-1:0]   r_phase;
    logic [15:0]            r_gap;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_data;
    logic                   r_sclk;
    logic                   r_done;

    state_t                 w_state_nx;
    logic [191:0]           w_frame_nx;
    logic [7:0]             w_idx_nx;
    logic [c_phase_w-1:0]   w_phase_nx;
    logic [15:0]            w_gap_nx;
    logic                   w_done_nx;
    logic [7:0]             w_bit_sel;
    logic                   w_data_nx;
    logic                   w_sclk_nx;

    // Next-state, counter and output decode; outputs are computed from the
    // next state so every output pin comes straight from a flop.
    always_comb begin
        w_state_nx = r_state;
        w_frame_nx = r_frame;
        w_idx_nx   = r_idx;
        w_phase_nx = r_phase;
        w_gap_nx   = r_gap;
        w_done_nx  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_frame_nx = {PREAMBLE, TYPE_1, TYPE_2, CONSTANT,
                                  thermostat_id, room_temp, set_temp, state,
                                  tail_1, tail_2, tail_3};
                    w_idx_nx   = 8'd0;
                    w_phase_nx = '0;
                    w_state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_phase == c_phase_last) begin
                    w_phase_nx = '0;
                    if (r_idx == c_last_bit) begin
                        // Index parks at 191; it is reloaded on the next accept.
                        w_done_nx  = 1'b1;
                        w_gap_nx   = 16'd0;
                        w_state_nx = c_has_gap ? S_GAP : S_IDLE;
                    end else begin
                        w_idx_nx = r_idx + 8'd1;
                    end
                end else begin
                    w_phase_nx = r_phase + c_phase_one;
                end
            end
            S_GAP: begin
                if (r_gap == c_gap_last) begin
                    w_gap_nx   = 16'd0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_gap_nx = r_gap + 16'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_bit_sel = c_last_bit - w_idx_nx;
        w_data_nx = (w_state_nx == S_SHIFT) ? w_frame_nx[w_bit_sel] : 1'b0;
        w_sclk_nx = (w_state_nx == S_SHIFT) && (w_phase_nx == c_phase_strobe);
    end

    // State, frame, counters and registered outputs; reset wins over start.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_frame <= '0;
            r_idx   <= 8'd0;
            r_phase <= '0;
            r_gap   <= 16'd0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_data  <= 1'b0;
            r_sclk  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_frame <= w_frame_nx;
            r_idx   <= w_idx_nx;
            r_phase <= w_phase_nx;
            r_gap   <= w_gap_nx;
            r_ready <= (w_state_nx == S_IDLE);
            r_busy  <= (w_state_nx != S_IDLE);
            r_data  <= w_data_nx;
            r_sclk  <= w_sclk_nx;
            r_done  <= w_done_nx;
        end
    end

    assign ready        = r_ready;
    assign busy         = r_busy;
    assign serial_data  = r_data;
    assign serial_clock = r_sclk;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_encode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_encode
//  Description : Scoreboard bench for serial_encode. Four instances with
//                different bit periods / gaps; stimulus pushes expected
//                strobes, done and ready events, a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_encode;

    localparam logic [95:0]  c_hdr = 96'hAAAAAAAA_D391_D391_0DFFFFFE;
    localparam logic [191:0] c_def = 192'hAAAAAAAA_D391_D391_0DFFFFFE_02391F9F_00C0_00C8_64_50_0C_4A;
    localparam logic [191:0] c_frb = 192'hAAAAAAAA_D391_D391_0DFFFFFE_12345678_0100_0200_01_FF_00_A5;
    localparam logic [191:0] c_frc = 192'hAAAAAAAA_D391_D391_0DFFFFFE_FFFF0000_7FFF_8000_80_7E_81_3C;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  start;
    logic [31:0] thermostat_id;
    logic [15:0] room_temp;
    logic [15:0] set_temp;
    logic [7:0]  state_in;
    logic [7:0]  tail_1;
    logic [7:0]  tail_2;
    logic [7:0]  tail_3;
    wire  [3:0]  ready;
    wire  [3:0]  busy;
    wire  [3:0]  done;
    wire  [3:0]  sdata;
    wire  [3:0]  sclk;

    always #5 clock = ~clock;

    function automatic int per_of(input int i);
        case (i)
            0:       return 4;
            1:       return 2;
            2:       return 5;
            default: return 255;
        endcase
    endfunction

    function automatic int gap_of(input int i);
        case (i)
            0:       return 16;
            1:       return 0;
            2:       return 16;
            default: return 3;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_encode #(
            .BIT_PERIOD ((g == 0) ? 4  : (g == 1) ? 2 : (g == 2) ? 5  : 255),
            .GAP_CYCLES ((g == 0) ? 16 : (g == 1) ? 0 : (g == 2) ? 16 : 3)
        ) u_dut (
            .clock         (clock),
            .reset         (reset),
            .start         (start[g]),
            .ready         (ready[g]),
            .thermostat_id (thermostat_id),
            .room_temp     (room_temp),
            .set_temp      (set_temp),
            .state         (state_in),
            .tail_1        (tail_1),
            .tail_2        (tail_2),
            .tail_3        (tail_3),
            .serial_data   (sdata[g]),
            .serial_clock  (sclk[g]),
            .busy          (busy[g]),
            .done          (done[g])
        );
    end

    typedef struct { int inst; int cyc; logic val; } sb_t;
    typedef struct { int inst; int cyc; } ev_t;
    typedef struct { int inst; logic [4:0] val; } snap_t;

    sb_t   sb_q[$];
    ev_t   done_q[$];
    ev_t   ready_q[$];
    snap_t snap_q[$];

    int   checks = 0;
    int   errors = 0;
    logic end_req = 1'b0;
    logic end_done = 1'b0;

    // Expected strobe bits, done and ready-return cycles for one frame.
    task automatic push_frame(input int inst, input logic [191:0] fr);
        sb_t e;
        ev_t v;
        int  p;
        p = per_of(inst);
        for (int k = 0; k < 192; k++) begin
            e.inst = inst;
            e.cyc  = 1 + k * p + p / 2;
            e.val  = fr[191 - k];
            sb_q.push_back(e);
        end
        v.inst = inst;
        v.cyc  = 1 + 192 * p;
        done_q.push_back(v);
        v.cyc  = 1 + 192 * p + gap_of(inst);
        ready_q.push_back(v);
    endtask

    task automatic set_payload(input logic [191:0] fr);
        {thermostat_id, room_temp, set_temp, state_in, tail_1, tail_2, tail_3} = fr[95:0];
    endtask

    task automatic snap(input int inst, input logic [4:0] val);
        snap_t s;
        s.inst = inst;
        s.val  = val;
        snap_q.push_back(s);
    endtask

    // Called at a falling edge with the instance idle; returns at the
    // falling edge of cycle 1.
    task automatic send(input int inst, input logic [191:0] fr, input bit hold);
        set_payload(fr);
        push_frame(inst, fr);
        start[inst] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (!hold) start[inst] = 1'b0;
    endtask

    // Monitor: cycle counting from each accept edge, scoreboard pops.
    always begin : p_monitor
        sb_t        e;
        ev_t        v;
        snap_t      s;
        logic [3:0] acc;
        logic       rst_seen;
        logic [4:0] act;
        int         cyc [4];
        logic [3:0] prev_ready;
        @(posedge clock);
        acc      = start & ready & {4{~reset}};
        rst_seen = reset;
        #1;
        if (rst_seen === 1'b1) begin
            sb_q.delete();
            done_q.delete();
            ready_q.delete();
        end
        while (snap_q.size() > 0) begin
            s   = snap_q.pop_front();
            act = {ready[s.inst], busy[s.inst], done[s.inst], sclk[s.inst], sdata[s.inst]};
            checks++;
            if (act !== s.val) begin
                errors++;
                $display("FAIL snapshot inst%0d: {ready,busy,done,sclk,data} got %b, required %b", s.inst, act, s.val);
            end
        end
        for (int g = 0; g < 4; g++) begin
            if (acc[g] === 1'b1) cyc[g] = 1;
            else                 cyc[g] = cyc[g] + 1;
            if (sclk[g] === 1'b1) begin
                checks++;
                if (sb_q.size() == 0 || sb_q[0].inst != g) begin
                    errors++;
                    $display("FAIL strobe inst%0d: got strobe at cycle %0d, required none", g, cyc[g]);
                end else begin
                    e = sb_q.pop_front();
                    if (e.cyc != cyc[g] || e.val !== sdata[g]) begin
                        errors++;
                        $display("FAIL strobe inst%0d: got data %b at cycle %0d, required data %b at cycle %0d",
                                 g, sdata[g], cyc[g], e.val, e.cyc);
                    end
                end
            end
            if (done[g] === 1'b1) begin
                checks++;
                if (done_q.size() == 0 || done_q[0].inst != g) begin
                    errors++;
                    $display("FAIL done inst%0d: got done at cycle %0d, required none", g, cyc[g]);
                end else begin
                    v = done_q.pop_front();
                    if (v.cyc != cyc[g]) begin
                        errors++;
                        $display("FAIL done inst%0d: got done at cycle %0d, required cycle %0d", g, cyc[g], v.cyc);
                    end
                end
            end
            if (rst_seen !== 1'b1 && ready[g] === 1'b1 && prev_ready[g] === 1'b0) begin
                checks++;
                if (ready_q.size() == 0 || ready_q[0].inst != g) begin
                    errors++;
                    $display("FAIL ready inst%0d: got ready rise at cycle %0d, required none", g, cyc[g]);
                end else begin
                    v = ready_q.pop_front();
                    if (v.cyc != cyc[g]) begin
                        errors++;
                        $display("FAIL ready inst%0d: got ready rise at cycle %0d, required cycle %0d", g, cyc[g], v.cyc);
                    end
                end
            end
            prev_ready[g] = ready[g];
        end
        if (end_req && !end_done) begin
            checks++;
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL leftover strobes: got %0d missing, required 0", sb_q.size());
            end
            checks++;
            if (done_q.size() != 0) begin
                errors++;
                $display("FAIL leftover done: got %0d missing, required 0", done_q.size());
            end
            checks++;
            if (ready_q.size() != 0) begin
                errors++;
                $display("FAIL leftover ready: got %0d missing, required 0", ready_q.size());
            end
            end_done = 1'b1;
        end
    end

    // Directed stimulus.
    initial begin : p_stim
        logic [191:0] rf;
        reset = 1'b1;
        start = 4'b0000;
        set_payload(192'd0);
        repeat (3) @(negedge clock);
        for (int i = 0; i < 4; i++) snap(i, 5'b10000);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Default payload, P=4, G=16: strobes from cycle 3, done 769, ready 785.
        send(0, c_def, 1'b0);
        repeat (778) @(negedge clock);
        snap(0, 5'b01000);
        repeat (10) @(negedge clock);
        snap(0, 5'b10000);
        @(negedge clock);

        // Random payload captured, then toggled every cycle; start pulsed in SHIFT and GAP.
        rf = {c_hdr, 32'($urandom), 16'($urandom), 16'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        send(0, rf, 1'b0);
        for (int c = 1; c <= 790; c++) begin
            start[0] = (c == 50 || c == 775);
            thermostat_id = 32'($urandom);
            room_temp     = 16'($urandom);
            set_temp      = 16'($urandom);
            state_in      = 8'($urandom);
            {tail_1, tail_2, tail_3} = 24'($urandom);
            @(negedge clock);
        end
        start[0] = 1'b0;

        // P=2, G=0, start held: three back-to-back frames, payload changed after each accept.
        send(1, c_def, 1'b1);
        push_frame(1, c_frb);
        push_frame(1, c_frc);
        set_payload(c_frb);
        repeat (385) @(negedge clock);
        set_payload(c_frc);
        repeat (385) @(negedge clock);
        start[1] = 1'b0;
        set_payload(192'hFFFF);
        repeat (390) @(negedge clock);

        // P=5: reset on the edge that would issue the bit-100 strobe, then a fresh frame.
        send(2, c_def, 1'b0);
        repeat (501) @(negedge clock);
        reset = 1'b1;
        snap(2, 5'b10000);
        @(negedge clock);
        reset = 1'b0;
        snap(2, 5'b10000);
        repeat (5) @(negedge clock);
        send(2, c_frb, 1'b0);
        repeat (1 + 960 + 16 + 5) @(negedge clock);

        // start together with reset is dropped.
        start[0] = 1'b1;
        reset    = 1'b1;
        snap(0, 5'b10000);
        @(negedge clock);
        start[0] = 1'b0;
        reset    = 1'b0;
        snap(0, 5'b10000);
        repeat (20) @(negedge clock);

        // P=255: strobe at phase 127, first and last bits checked on their strobes.
        send(3, c_def, 1'b0);
        repeat (1 + 192 * 255 + 3 + 5) @(negedge clock);
        snap(3, 5'b10000);
        @(negedge clock);

        end_req = 1'b1;
        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_encode.md
# serial_encode

Transmit side of the thermostat serial link. Serializes one 192-bit frame MSB-first onto a data line with a one-cycle sample strobe; the field order and widths match the receiver's shift-register layout. It drives the link in loopback benches against the receive path and emulates a thermostat on hardware. Header fields are compile-time constants; payload fields are captured on a start/ready handshake.

## Interface
- `PREAMBLE`, 32'hAAAA_AAAA, frame bits 191:160
- `TYPE_1`, 16'hD391, bits 159:144
- `TYPE_2`, 16'hD391, bits 143:128
- `CONSTANT`, 32'h0DFF_FFFE, bits 127:96
- `BIT_PERIOD`, 4, clocks per serial bit; legal range 2..255
- `GAP_CYCLES`, 16, idle clocks after a frame before `ready` reasserts; legal range 0..65535

- `clock`  in  1  single clock; every flop is on its rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request to send; accepted on a cycle where `start && ready`
- `ready`  out  1  idle and able to accept `start`
- `thermostat_id`  in  32  frame bits 95:64
- `room_temp`  in  16  frame bits 63:48
- `set_temp`  in  16  frame bits 47:32
- `state`  in  8  frame bits 31:24
- `tail_1`, `tail_2`, `tail_3`  in  8 each  frame bits 23:16, 15:8, 7:0
- `serial_data`  out  1  current frame bit
- `serial_clock`  out  1  one-cycle strobe; the receiver samples `serial_data` while this is high
- `busy`  out  1  a frame is in flight, including the gap
- `done`  out  1  one-cycle pulse when the last bit period ends

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE:
  - `ready`=1, `busy`=0, `serial_data`=0, `serial_clock`=0.
  - On `start`, capture {constants, payload inputs} into a 192-bit frame register. Payload inputs are ignored at all other times.
  - Clear the bit index to 0 and the phase counter to 0, then enter SHIFT.
- SHIFT:
  - `serial_data` = frame[191 − bit index], held for the full bit period.
  - The phase counter counts 0..BIT_PERIOD−1.
  - `serial_clock`=1 on exactly the cycle where phase == BIT_PERIOD/2 (integer division).
  - At phase BIT_PERIOD−1 the index increments.
  - When index 191 completes: pulse `done` for one cycle, then go to GAP.
- GAP:
  - `serial_data`=0, `serial_clock`=0.
  - Count GAP_CYCLES clocks, then return to IDLE.
  - With GAP_CYCLES=0, go from SHIFT straight to IDLE.
- `busy` = state ≠ IDLE. `ready` = state == IDLE.
- Exactly 192 strobes per frame. No strobe ever occurs outside SHIFT.
- Arithmetic:
  - Bit index is 8 bits and never wraps past 191.
  - The phase counter is $clog2(BIT_PERIOD) bits wide, minimum 1.
  - The gap counter is 16 bits.
- `start` while `ready`=0 is ignored and is not queued.
- `start` held high is accepted again as soon as `ready` returns, which gives back-to-back frames.
- Reset (a clock edge with `reset`=1):
  - Applies in any state, including mid-frame.
  - Enters IDLE; frame register and all counters cleared.
  - `ready`=1; `busy`, `done`, `serial_clock`, `serial_data` all 0.
  - No partial strobe or `done` is issued on the reset edge or after it.
  - `start` coincident with `reset` is dropped.

## Timing
- Accept edge = cycle 0. SHIFT begins at cycle 1.
- Bit k (k=0..191, k=0 = MSB of PREAMBLE) occupies cycles 1+k·P .. k·P+P, with P = BIT_PERIOD.
- The strobe for bit k is at cycle 1+k·P+P/2.
- `done` is high at cycle 1+192·P.
- `ready` returns at cycle 1+192·P+GAP_CYCLES.
- All outputs are registered: no combinational path from any input to any output.
- The data bit is stable at least P/2 cycles before its strobe and at least P−1−P/2 cycles after it.
  - P=2 gives 1 cycle before and 0 after. The receiver samples on the same edge, so this is legal.

## Test plan
- Default parameters, payload thermostat_id=32'h02391F9F, room_temp=16'h00C0, set_temp=16'h00C8, state=8'h64, tails=8'h50/8'h0C/8'h4A, looped into the receiver:
  - Receiver fields match the sent values bit-for-bit.
  - `valid` rises on the 192nd strobe.
  - Exactly 192 strobes, first at cycle 3, `done` at cycle 769, `ready` at cycle 785.
- BIT_PERIOD=2, GAP_CYCLES=0, `start` held high for 3 frames:
  - Each frame yields 192 strobes, 2 cycles apart.
  - Each new frame starts at the cycle after `done`.
  - Payload changes between frames appear only in later frames.
- Payload inputs toggled randomly every cycle after acceptance:
  - Transmitted bits equal the values captured on the accept edge.
- `reset` asserted at bit 100, phase P/2, with BIT_PERIOD=5:
  - No strobe on that edge; all outputs at reset values the next cycle.
  - A fresh `start` then produces a complete correct frame from the PREAMBLE MSB.
- `start` pulsed during SHIFT and during GAP:
  - Ignored; no extra frame is sent.
  - `start` and `reset` asserted together: no frame is sent.
- BIT_PERIOD=255:
  - Strobe at phase 127 of each bit.
  - Bit 0 = 1 and bit 191 = tail_3[0] are observed on their strobes.
